// File: rtl/audio_level_meter_pkg.sv
// Shared widths and helpers for the audio level meter.
package audio_level_meter_pkg;

  localparam int unsigned SMP_W = 12;
  localparam int unsigned MAG_W = 11;
  localparam int unsigned PWM_W = 8;
  localparam logic [SMP_W-1:0] SILENCE = 12'h800;

  // Offset-binary sample to magnitude; both codes either side of 0x800 fold to 0.
  function automatic logic [MAG_W-1:0] sample_mag(input logic [SMP_W-1:0] s);
    return s[SMP_W-1] ? s[MAG_W-1:0] : ~s[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/audio_level_meter_edge_sync.sv
// Two-flop synchroniser followed by a single-cycle rising-edge detector.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  // Synchroniser chain plus history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/audio_level_meter.sv
// Envelope follower (instant attack, linear release) driving an LED bar and a PWM lamp.
module audio_level_meter
  import audio_level_meter_pkg::*;
#(
  parameter int unsigned NLED       = 8,
  parameter int unsigned DECAY_DIV  = 64,
  parameter int unsigned DECAY_STEP = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             smp_clk,
  input  logic [SMP_W-1:0] smp_data,
  output logic [MAG_W-1:0] level,
  output logic             level_valid,
  output logic [NLED-1:0]  leds,
  output logic             pwm
);

  localparam int unsigned DcntW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DcntW-1:0] DcntMax = DcntW'(DECAY_DIV - 1);
  localparam logic [MAG_W-1:0] DecStep = MAG_W'(DECAY_STEP);
  localparam int unsigned LedStep = 2048 / NLED;

  logic             strobe;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] env, env_d;
  logic [DcntW-1:0] dcnt, dcnt_d;
  logic             upd;
  logic [NLED-1:0]  leds_d;
  logic [PWM_W-1:0] pcnt;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .d     (smp_clk),
    .rise  (strobe)
  );

  assign mag = sample_mag(smp_data);

  // Envelope next state: attack wins over a coincident release tick.
  always_comb begin
    env_d  = env;
    dcnt_d = dcnt;
    if (strobe) begin
      if (mag > env) begin
        env_d  = mag;
        dcnt_d = '0;
      end else if (dcnt == DcntMax) begin
        dcnt_d = '0;
        env_d  = (env > DecStep) ? env - DecStep : '0;
      end else begin
        dcnt_d = dcnt + 1'b1;
      end
    end
  end

  // Envelope and release-divider state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env  <= '0;
      dcnt <= '0;
    end else begin
      env  <= env_d;
      dcnt <= dcnt_d;
    end
  end

  // Thermometer decode; each LED lights half a step above its segment base.
  always_comb begin
    leds_d = '0;
    for (int unsigned i = 0; i < NLED; i++) begin
      leds_d[i] = (32'(env) >= i * LedStep + LedStep / 2);
    end
  end

  // Registered level, LED bar and update pulse, one clk after env changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd         <= 1'b0;
      level       <= '0;
      level_valid <= 1'b0;
      leds        <= '0;
    end else begin
      upd         <= strobe;
      level       <= env;
      level_valid <= upd;
      leds        <= leds_d;
    end
  end

  // Free-running PWM ramp compared against the top bits of level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      pwm  <= 1'b0;
    end else begin
      pcnt <= pcnt + 1'b1;
      pwm  <= (level[MAG_W-1:MAG_W-PWM_W] > pcnt);
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with hand-computed expectations.
module tb_audio_level_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        smp_clk = 1'b0;
  logic [11:0] smp_data = 12'h800;
  logic [10:0] level;
  logic        level_valid;
  logic [7:0]  leds;
  logic        pwm;

  int n_checks = 0;
  int n_bad = 0;

  audio_level_meter #(
    .NLED       (8),
    .DECAY_DIV  (4),
    .DECAY_STEP (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .smp_clk     (smp_clk),
    .smp_data    (smp_data),
    .level       (level),
    .level_valid (level_valid),
    .leds        (leds),
    .pwm         (pwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample: raise smp_clk at a negedge, record which posedge shows level_valid.
  task automatic send(input logic [11:0] d, output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    @(negedge clk);
    smp_data = d;
    smp_clk  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (level_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    @(negedge clk);
    smp_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_q(input logic [11:0] d);
    int l, p;
    send(d, l, p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic count_pwm(output int hi);
    hi = 0;
    repeat (256) begin
      @(posedge clk);
      #1;
      if (pwm) hi++;
    end
  endtask

  int lat, pulses, hi;
  int rel_exp [8] = '{1024, 1024, 1024, 1008, 1008, 1008, 1008, 992};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(level_valid), 0);
    check("rst_leds", int'(leds), 0);
    check("rst_pwm", int'(pwm), 0);
    @(negedge clk);
    reset = 1'b0;

    count_pwm(hi);
    check("pwm_zero", hi, 0);

    // Attack
    send(12'hC00, lat, pulses);
    check("atk_latency", lat, 4);
    check("atk_pulses", pulses, 1);
    check("atk_level", int'(level), 1024);
    check("atk_leds", int'(leds), 8'h0F);
    count_pwm(hi);
    check("pwm_half", hi, 128);

    // Release: steps only on every 4th strobe
    for (int i = 0; i < 8; i++) begin
      send_q(12'h800);
      check($sformatf("rel_%0d", i), int'(level), rel_exp[i]);
    end

    // Full scale both polarities
    do_reset();
    send_q(12'h000);
    check("fs_000", int'(level), 2047);
    check("fs_leds", int'(leds), 8'hFF);
    send_q(12'hFFF);
    check("fs_fff", int'(level), 2047);
    send_q(12'h7FF);
    check("fs_7ff", int'(level), 2047);
    count_pwm(hi);
    check("pwm_full", hi, 255);

    // Release saturates at zero
    do_reset();
    send_q(12'h80A);
    check("sat_start", int'(level), 10);
    for (int i = 0; i < 3; i++) send_q(12'h800);
    check("sat_hold", int'(level), 10);
    send_q(12'h800);
    check("sat_zero", int'(level), 0);
    for (int i = 0; i < 4; i++) send_q(12'h800);
    check("sat_nowrap", int'(level), 0);

    // Attack coincident with release tick
    do_reset();
    send_q(12'hBE8);
    check("coin_start", int'(level), 1000);
    for (int i = 0; i < 3; i++) send_q(12'h800);
    check("coin_pre", int'(level), 1000);
    send_q(12'hC4C);
    check("coin_atk", int'(level), 1100);
    check("coin_leds", int'(leds), 8'h0F);
    for (int i = 0; i < 3; i++) send_q(12'h800);
    check("coin_dcnt0", int'(level), 1100);
    send_q(12'h800);
    check("coin_tick", int'(level), 1084);

    // Asynchronous reset mid-stream
    do_reset();
    send_q(12'hDDC);
    check("mid_level", int'(level), 1500);
    check("mid_leds", int'(leds), 8'h3F);
    hi = 0;
    for (int k = 0; k < 300 && hi == 0; k++) begin
      @(posedge clk);
      #1;
      if (pwm) hi = 1;
    end
    check("mid_pwm_high", hi, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_leds", int'(leds), 0);
    check("mid_rst_pwm", int'(pwm), 0);
    @(negedge clk);
    reset = 1'b0;
    send(12'h800, lat, pulses);
    check("post_rst_lat", lat, 4);
    check("post_rst_level", int'(level), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
